// File: rtl/classify_pkg.sv
// classify_pkg: constants and result type shared by the classification pipeline back end
package classify_pkg;
    localparam int RULE_ID_W    = 14;
    localparam int SEQ_W        = 16;
    localparam int PIPE_LATENCY = 11;
    typedef struct packed {
        logic [RULE_ID_W-1:0] rule_id;
        logic                 matched;
        logic [SEQ_W-1:0]     seq;
    } result_t;
endpackage

// File: rtl/dual_write_fifo.sv
// dual_write_fifo: 2-write/1-read first-word-fall-through register FIFO with occupancy count
module dual_write_fifo #(
    parameter  int W     = 31,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   wr_n_i,
    input  logic [W-1:0] wd0_i,
    input  logic [W-1:0] wd1_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_data_o,
    output logic [AW:0]  count_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_n_i != 2'd0) mem_q[wptr_q] <= wd0_i;
            if (wr_n_i == 2'd2) mem_q[wptr_q + 1'b1] <= wd1_i;
            wptr_q  <= wptr_q + AW'(wr_n_i);
            rptr_q  <= rptr_q + AW'(pop_i);
            count_q <= count_q + (AW+1)'(wr_n_i) - (AW+1)'(pop_i);
        end
    end
    // when empty, show the most recently popped entry so the outputs hold still
    assign rd_data_o = mem_q[(count_q == '0) ? rptr_q - 1'b1 : rptr_q];
    assign count_o   = count_q;
endmodule

// File: rtl/classify_result_merger.sv
// classify_result_merger: merges two lane results in order into a sequence-tagged FWFT stream
module classify_result_merger
    import classify_pkg::*;
#(
    parameter int RULE_ID      = RULE_ID_W,
    parameter int SEQ_WIDTH    = SEQ_W,
    parameter int FIFO_DEPTH   = 64,
    parameter int AFULL_MARGIN = 24,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 RSTn,
    input  logic [RULE_ID-1:0]   rule_id1,
    input  logic                 action_valid1,
    input  logic                 data_valid_out1,
    input  logic [RULE_ID-1:0]   rule_id2,
    input  logic                 action_valid2,
    input  logic                 data_valid_out2,
    output logic [RULE_ID-1:0]   res_rule_id,
    output logic                 res_matched,
    output logic [SEQ_WIDTH-1:0] res_seq,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 almost_full,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] drop_count,
    input  logic                 clear_stats
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int W  = RULE_ID + 1 + SEQ_WIDTH;
    if (AFULL_MARGIN < 2 * PIPE_LATENCY) begin : g_bad_margin
        $error("AFULL_MARGIN too small for in-flight pipeline results");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 4");
    end
    logic [AW:0]            count, count_nxt;
    logic [AW+1:0]          free;
    logic [1:0]             n_arr, n_wr, n_drop;
    logic                   pop;
    logic [W-1:0]           wd0, wd1, rd;
    logic [SEQ_WIDTH-1:0]   seq_q, seq2;
    logic                   afull_q, ovf_q;
    logic [CNT_WIDTH-1:0]   drop_q;
    logic [CNT_WIDTH:0]     drop_sum;
    assign res_valid = count != '0;
    assign pop       = res_valid & res_ready;
    assign free      = (AW+2)'(FIFO_DEPTH) - {1'b0, count} + (AW+2)'(pop);
    assign n_arr     = {1'b0, data_valid_out1} + {1'b0, data_valid_out2};
    assign n_wr      = (free >= (AW+2)'(2)) ? n_arr :
                       (free == (AW+2)'(1) && n_arr != 2'd0) ? 2'd1 : 2'd0;
    assign n_drop    = n_arr - n_wr;
    assign count_nxt = count + (AW+1)'(n_wr) - (AW+1)'(pop);
    // lane 2 takes the tag after lane 1 only when lane 1 also arrived
    assign seq2      = seq_q + SEQ_WIDTH'(data_valid_out1);
    assign wd1       = {rule_id2, action_valid2, seq2};
    assign wd0       = data_valid_out1 ? {rule_id1, action_valid1, seq_q} : wd1;
    assign drop_sum  = {1'b0, drop_q} + (CNT_WIDTH+1)'(n_drop);
    dual_write_fifo #(.W(W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (RSTn),
        .wr_n_i    (n_wr),
        .wd0_i     (wd0),
        .wd1_i     (wd1),
        .pop_i     (pop),
        .rd_data_o (rd),
        .count_o   (count)
    );
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            seq_q   <= '0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            seq_q   <= seq_q + SEQ_WIDTH'(n_arr);
            afull_q <= count_nxt >= (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);
            ovf_q   <= (ovf_q & ~clear_stats) | (n_drop != 2'd0);
            drop_q  <= clear_stats ? CNT_WIDTH'(n_drop) :
                       drop_sum[CNT_WIDTH] ? '1 : drop_sum[CNT_WIDTH-1:0];
        end
    end
    assign {res_rule_id, res_matched, res_seq} = rd;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;
    assign drop_count  = drop_q;
endmodule

// File: tb/tb_classify_result_merger.sv
// tb_classify_result_merger: directed self-checking bench for classify_result_merger
module tb_classify_result_merger;
    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic [13:0] rule_id1 = '0, rule_id2 = '0;
    logic        action_valid1 = 1'b0, action_valid2 = 1'b0;
    logic        data_valid_out1 = 1'b0, data_valid_out2 = 1'b0;
    logic [13:0] res_rule_id;
    logic        res_matched, res_valid, almost_full, overflow;
    logic [15:0] res_seq, drop_count;
    logic        res_ready = 1'b0, clear_stats = 1'b0;
    int          errors = 0, checks = 0;

    classify_result_merger dut (
        .clk(clk), .RSTn(RSTn),
        .rule_id1(rule_id1), .action_valid1(action_valid1), .data_valid_out1(data_valid_out1),
        .rule_id2(rule_id2), .action_valid2(action_valid2), .data_valid_out2(data_valid_out2),
        .res_rule_id(res_rule_id), .res_matched(res_matched), .res_seq(res_seq),
        .res_valid(res_valid), .res_ready(res_ready), .almost_full(almost_full),
        .overflow(overflow), .drop_count(drop_count), .clear_stats(clear_stats)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic v1, input logic [13:0] r1, input logic m1,
                         input logic v2, input logic [13:0] r2, input logic m2);
        data_valid_out1 = v1; rule_id1 = r1; action_valid1 = m1;
        data_valid_out2 = v2; rule_id2 = r2; action_valid2 = m2;
    endtask

    task automatic do_reset();
        lanes(0, 0, 0, 0, 0, 0);
        res_ready = 0; clear_stats = 0;
        RSTn = 0;
        step();
        RSTn = 1;
    endtask

    initial begin
        // 1: reset values, then one two-lane arrival popped in order
        do_reset();
        chk("rst_valid", res_valid, 0);
        chk("rst_rule", res_rule_id, 0);
        chk("rst_match", res_matched, 0);
        chk("rst_seq", res_seq, 0);
        chk("rst_afull", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_drop", drop_count, 0);
        res_ready = 1;
        lanes(1, 5, 1, 1, 9, 0);
        step();
        lanes(0, 0, 0, 0, 0, 0);
        chk("t1_valid0", res_valid, 1);
        chk("t1_rule0", res_rule_id, 5);
        chk("t1_match0", res_matched, 1);
        chk("t1_seq0", res_seq, 0);
        step();
        chk("t1_valid1", res_valid, 1);
        chk("t1_rule1", res_rule_id, 9);
        chk("t1_match1", res_matched, 0);
        chk("t1_seq1", res_seq, 1);
        step();
        chk("t1_empty", res_valid, 0);

        // 2: lane 2 only, held by the sink, then drained
        do_reset();
        lanes(0, 0, 0, 1, 3, 1);
        step(); step(); step();
        lanes(0, 0, 0, 0, 0, 0);
        chk("t2_valid", res_valid, 1);
        chk("t2_rule", res_rule_id, 3);
        chk("t2_seq_hold", res_seq, 0);
        step();
        chk("t2_stable_valid", res_valid, 1);
        chk("t2_stable_seq", res_seq, 0);
        res_ready = 1;
        step();
        chk("t2_pop_seq1", res_seq, 1);
        step();
        chk("t2_pop_seq2", res_seq, 2);
        step();
        chk("t2_empty", res_valid, 0);

        // 3: fill until almost_full, then partial and full drops
        do_reset();
        lanes(1, 1, 1, 1, 2, 0);
        for (int i = 0; i < 31; i++) begin
            step();
            if (i == 18) chk("t3_afull_38", almost_full, 0);
            if (i == 19) chk("t3_afull_40", almost_full, 1);
        end
        chk("t3_ovf_62", overflow, 0);
        lanes(1, 1, 1, 0, 0, 0);
        step();
        chk("t3_ovf_63", overflow, 0);
        lanes(1, 1, 1, 1, 2, 0);
        step();
        chk("t3_ovf_set", overflow, 1);
        chk("t3_drop1", drop_count, 1);
        step();
        chk("t3_drop3", drop_count, 3);
        chk("t3_head_seq", res_seq, 0);

        // 4: full FIFO, pop and write in the same cycle
        res_ready = 1;
        lanes(1, 11, 1, 0, 0, 0);
        step();
        lanes(0, 0, 0, 0, 0, 0);
        chk("t4_drop_same", drop_count, 3);
        chk("t4_afull", almost_full, 1);
        chk("t4_head_seq", res_seq, 1);
        chk("t4_head_rule", res_rule_id, 2);
        for (int i = 0; i < 64; i++) begin
            chk("t4_drain_valid", res_valid, 1);
            chk("t4_drain_seq", res_seq, (i < 63) ? i + 1 : 67);
            if (i == 63) chk("t4_last_rule", res_rule_id, 11);
            step();
        end
        chk("t4_empty", res_valid, 0);
        chk("t4_afull_off", almost_full, 0);

        // 5: clear_stats coinciding with a two-result drop
        do_reset();
        lanes(1, 1, 1, 1, 2, 0);
        for (int i = 0; i < 32; i++) step();
        chk("t5_full_ovf", overflow, 0);
        step();
        chk("t5_ovf", overflow, 1);
        chk("t5_drop2", drop_count, 2);
        clear_stats = 1;
        step();
        chk("t5_clr_drop_ovf", overflow, 1);
        chk("t5_clr_drop_cnt", drop_count, 2);
        lanes(0, 0, 0, 0, 0, 0);
        step();
        clear_stats = 0;
        chk("t5_clr_ovf", overflow, 0);
        chk("t5_clr_cnt", drop_count, 0);

        // 6: asynchronous reset mid-stream
        do_reset();
        lanes(1, 1, 1, 1, 2, 0);
        for (int i = 0; i < 5; i++) step();
        lanes(0, 0, 0, 0, 0, 0);
        chk("t6_pre_valid", res_valid, 1);
        #2 RSTn = 0;
        #1;
        chk("t6_async_valid", res_valid, 0);
        chk("t6_async_afull", almost_full, 0);
        step();
        RSTn = 1;
        lanes(1, 7, 1, 0, 0, 0);
        step();
        lanes(0, 0, 0, 0, 0, 0);
        chk("t6_after_valid", res_valid, 1);
        chk("t6_after_rule", res_rule_id, 7);
        chk("t6_after_seq", res_seq, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
